// File: rtl/xpb_pkg.sv
// Shared defaults and FSM state encoding for the runtime k*BASE mod MODULUS table generator.
// Imported by the generator top; holds no logic.
package xpb_pkg;

  localparam int DEF_WORD_BITS = 1024;
  localparam int DEF_SEG_BITS  = 5;
  localparam int DEF_NUM_PORTS = 2;
  localparam int DEF_DEPTH     = 1 << DEF_SEG_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } xpb_state_e;

endpackage

// File: rtl/xpb_modadd.sv
// Combinational (a+b) mod m for a,b < m; the sum is formed one bit wider so the carry survives.
// Zero latency, no flow control.
module xpb_modadd #(
  parameter int WORD_BITS = 1024
) (
  input  logic [WORD_BITS-1:0] a,
  input  logic [WORD_BITS-1:0] b,
  input  logic [WORD_BITS-1:0] m,
  output logic [WORD_BITS-1:0] sum
);

  logic [WORD_BITS:0] raw;
  logic               wrap;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b};
    wrap = (raw >= {1'b0, m});
    // With a,b < m a single conditional subtract brings the result back below m.
    sum  = WORD_BITS'(wrap ? (raw - {1'b0, m}) : raw);
  end

endmodule

// File: rtl/xpb_lut_gen.sv
// Builds entry[k] = k*BASE mod MODULUS one entry per cycle after gen_start (done 2^SEG_BITS cycles later);
// independent registered read ports with 1-cycle latency, no backpressure; reads return 0 until the table is ready.
module xpb_lut_gen
  import xpb_pkg::*;
#(
  parameter int WORD_BITS = DEF_WORD_BITS,
  parameter int SEG_BITS  = DEF_SEG_BITS,
  parameter int NUM_PORTS = DEF_NUM_PORTS
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           gen_start,
  input  logic [WORD_BITS-1:0]           gen_base,
  input  logic [WORD_BITS-1:0]           gen_modulus,
  output logic                           gen_busy,
  output logic                           gen_done,
  output logic                           gen_err,
  output logic                           table_ready,
  input  logic [NUM_PORTS-1:0]           rd_req,
  input  logic [NUM_PORTS*SEG_BITS-1:0]  rd_idx,
  output logic [NUM_PORTS-1:0]           rd_vld,
  output logic [NUM_PORTS*WORD_BITS-1:0] rd_data
);

  localparam int                  DEPTH    = 1 << SEG_BITS;
  localparam logic [SEG_BITS-1:0] LAST_IDX = SEG_BITS'(DEPTH - 1);

  xpb_state_e           state, state_nxt;
  logic [WORD_BITS-1:0] base_q, mod_q, acc_q, acc_nxt;
  logic [SEG_BITS-1:0]  ptr_q;
  logic                 start_ok, start_bad, fill_last;
  logic                 wr_en;
  logic [SEG_BITS-1:0]  wr_idx;
  logic [WORD_BITS-1:0] wr_dat;
  logic [WORD_BITS-1:0] mem [DEPTH];

  xpb_modadd #(.WORD_BITS(WORD_BITS)) u_modadd (
    .a   (acc_q),
    .b   (base_q),
    .m   (mod_q),
    .sum (acc_nxt)
  );

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    fill_last = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = ptr_q;
    wr_dat    = acc_q;
    case (state)
      IDLE: begin
        if (gen_start) begin
          if (gen_modulus == '0 || gen_base >= gen_modulus) begin
            start_bad = 1'b1;
          end else begin
            start_ok  = 1'b1;
            wr_en     = 1'b1;
            wr_idx    = '0;
            wr_dat    = '0;
            state_nxt = FILL;
          end
        end
      end
      FILL: begin
        wr_en = 1'b1;
        if (ptr_q == LAST_IDX) begin
          fill_last = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      base_q      <= '0;
      mod_q       <= '0;
      acc_q       <= '0;
      ptr_q       <= '0;
      gen_busy    <= 1'b0;
      gen_done    <= 1'b0;
      gen_err     <= 1'b0;
      table_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      gen_done <= fill_last;
      gen_err  <= start_bad;
      if (start_ok) begin
        base_q      <= gen_base;
        mod_q       <= gen_modulus;
        acc_q       <= gen_base;
        ptr_q       <= SEG_BITS'(1);
        gen_busy    <= 1'b1;
        table_ready <= 1'b0;
      end else if (state == FILL) begin
        acc_q <= acc_nxt;
        ptr_q <= ptr_q + 1'b1;
        if (fill_last) begin
          gen_busy    <= 1'b0;
          table_ready <= 1'b1;
        end
      end
    end
  end

  // Table contents deliberately survive reset; table_ready gates every read instead.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    logic [SEG_BITS-1:0]  idx;
    logic                 vld_q;
    logic [WORD_BITS-1:0] dat_q;

    assign idx = rd_idx[p*SEG_BITS +: SEG_BITS];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        vld_q <= rd_req[p];
        if (rd_req[p]) begin
          dat_q <= table_ready ? mem[idx] : '0;
        end
      end
    end

    assign rd_vld[p]                          = vld_q;
    assign rd_data[p*WORD_BITS +: WORD_BITS]  = dat_q;
  end

endmodule

// File: tb/tb_xpb_lut_gen.sv
// Directed bench for xpb_lut_gen: a 16-bit/8-entry instance for protocol and values, plus a
// default-size instance for the 1024-bit carry case.
module tb_xpb_lut_gen;

  localparam int W  = 16;
  localparam int S  = 3;
  localparam int P  = 2;
  localparam int BW = 1024;
  localparam int BS = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  logic           gen_start;
  logic [W-1:0]   gen_base, gen_modulus;
  logic           gen_busy, gen_done, gen_err, table_ready;
  logic [P-1:0]   rd_req, rd_vld;
  logic [P*S-1:0] rd_idx;
  logic [P*W-1:0] rd_data;

  logic            b_start;
  logic [BW-1:0]   b_base, b_mod;
  logic            b_busy, b_done, b_err, b_ready;
  logic [1:0]      b_req, b_vld;
  logic [2*BS-1:0] b_idx;
  logic [2*BW-1:0] b_data;

  xpb_lut_gen #(.WORD_BITS(W), .SEG_BITS(S), .NUM_PORTS(P)) dut (
    .clk(clk), .reset_n(reset_n), .gen_start(gen_start), .gen_base(gen_base),
    .gen_modulus(gen_modulus), .gen_busy(gen_busy), .gen_done(gen_done), .gen_err(gen_err),
    .table_ready(table_ready), .rd_req(rd_req), .rd_idx(rd_idx), .rd_vld(rd_vld),
    .rd_data(rd_data)
  );

  xpb_lut_gen #(.WORD_BITS(BW), .SEG_BITS(BS), .NUM_PORTS(2)) big (
    .clk(clk), .reset_n(reset_n), .gen_start(b_start), .gen_base(b_base),
    .gen_modulus(b_mod), .gen_busy(b_busy), .gen_done(b_done), .gen_err(b_err),
    .table_ready(b_ready), .rd_req(b_req), .rd_idx(b_idx), .rd_vld(b_vld),
    .rd_data(b_data)
  );

  int total = 0;
  int bad   = 0;

  logic [W-1:0] t1 [8] = '{16'd0, 16'd5, 16'd10, 16'd2, 16'd7, 16'd12, 16'd4, 16'd9};
  logic [W-1:0] t4 [8] = '{16'd0, 16'd3, 16'd6, 16'd9, 16'd1, 16'd4, 16'd7, 16'd10};

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Drive at a negedge, hold for one posedge; returns at the next negedge with start released.
  task automatic start(input logic [W-1:0] b, input logic [W-1:0] m);
    gen_start   = 1'b1;
    gen_base    = b;
    gen_modulus = m;
    @(negedge clk);
    gen_start   = 1'b0;
    gen_base    = 16'hFFFF;
    gen_modulus = 16'h0001;
  endtask

  // Called in cycle 1 after start; n is the cycle in which gen_done is seen (40 on timeout).
  task automatic wait_done(output int n);
    n = 1;
    while (!gen_done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic rd2(input logic [1:0] req, input logic [S-1:0] i0, input logic [S-1:0] i1);
    rd_req = req;
    rd_idx = {i1, i0};
    @(negedge clk);
    rd_req = '0;
  endtask

  task automatic check_table(input string tag, input logic [W-1:0] want [8]);
    for (int k = 0; k < 8; k++) begin
      rd2(2'b11, S'(k), S'(7 - k));
      chk($sformatf("%s_vld%0d", tag, k), rd_vld, 2'b11);
      chk($sformatf("%s_p0_e%0d", tag, k), rd_data[W-1:0], want[k]);
      chk($sformatf("%s_p1_e%0d", tag, 7 - k), rd_data[2*W-1:W], want[7 - k]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat, busy_cnt;
    logic seen_err;
    logic [BW-1:0] bb, bm, e2, e3, e31;

    reset_n = 1'b0; gen_start = 1'b0; gen_base = '0; gen_modulus = '0;
    rd_req = '0; rd_idx = '0;
    b_start = 1'b0; b_base = '0; b_mod = '0; b_req = '0; b_idx = '0;

    @(negedge clk);
    chk("rst_busy", gen_busy, 0);
    chk("rst_done", gen_done, 0);
    chk("rst_err", gen_err, 0);
    chk("rst_ready", table_ready, 0);
    chk("rst_vld", rd_vld, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_big_ready", b_ready, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Generation with base 5 mod 13
    start(16'h0005, 16'h000D);
    chk("t1_busy", gen_busy, 1);
    chk("t1_ready_low", table_ready, 0);
    wait_done(n);
    chk("t1_latency", n, 8);
    chk("t1_ready", table_ready, 1);
    chk("t1_busy_clr", gen_busy, 0);
    @(negedge clk);
    chk("t1_done_pulse", gen_done, 0);
    check_table("t1", t1);
    @(negedge clk);
    chk("hold_vld", rd_vld, 0);
    chk("hold_data", rd_data, 32'h0000_0009);

    // Rejected starts leave the old table in place
    start(16'h000D, 16'h000D);
    chk("t2a_err", gen_err, 1);
    chk("t2a_busy", gen_busy, 0);
    chk("t2a_ready", table_ready, 1);
    @(negedge clk);
    chk("t2a_err_pulse", gen_err, 0);
    start(16'h0005, 16'h0000);
    chk("t2b_err", gen_err, 1);
    chk("t2b_ready", table_ready, 1);
    @(negedge clk);

    // Same index on both ports, then a single-port read
    rd2(2'b11, 3'd3, 3'd3);
    chk("t3_vld", rd_vld, 2'b11);
    chk("t3_data", rd_data, 32'h0002_0002);
    rd2(2'b10, 3'd0, 3'd7);
    chk("t3b_vld", rd_vld, 2'b10);
    chk("t3b_data", rd_data, 32'h0009_0002);

    // Regenerate with an ignored second start and reads during FILL
    start(16'h0003, 16'h000B);
    n = 1; lat = 0; seen_err = 1'b0;
    while (lat == 0 && n < 40) begin
      if (gen_err) seen_err = 1'b1;
      if (n == 3) begin
        chk("t4_fill_vld", rd_vld[0], 1);
        chk("t4_fill_data", rd_data[W-1:0], 0);
      end
      if (n == 8) begin
        chk("t4_edge_vld", rd_vld[1], 1);
        chk("t4_edge_data", rd_data[2*W-1:W], 0);
      end
      if (gen_done) lat = n;
      gen_start   = (n == 4);
      gen_base    = 16'h0007;
      gen_modulus = 16'h0009;
      rd_req      = {n == 7, n == 2};
      rd_idx      = {3'd5, 3'd1};
      @(negedge clk);
      n++;
    end
    gen_start = 1'b0;
    rd_req    = '0;
    chk("t4_latency", lat, 8);
    chk("t4_no_err", seen_err, 0);
    check_table("t4", t4);

    // Reset in the middle of FILL
    start(16'h0005, 16'h000D);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t5_busy", gen_busy, 0);
    chk("t5_ready", table_ready, 0);
    chk("t5_done", gen_done, 0);
    chk("t5_err", gen_err, 0);
    chk("t5_vld", rd_vld, 0);
    chk("t5_data", rd_data, 0);
    @(negedge clk);
    reset_n  = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (table_ready || gen_busy) busy_cnt++;
    end
    chk("t5_idle_after", busy_cnt, 0);
    rd2(2'b01, 3'd2, 3'd0);
    chk("t5_rd_vld", rd_vld, 2'b01);
    chk("t5_rd_zero", rd_data[W-1:0], 0);
    start(16'h0005, 16'h000D);
    wait_done(n);
    chk("t5_regen_latency", n, 8);
    rd2(2'b11, 3'd6, 3'd1);
    chk("t5_regen_data", rd_data, 32'h0005_0004);

    // 1024-bit operands where the intermediate sum needs the extra bit
    bm  = '1;
    bb  = bm >> 1;
    e2  = bm - 1;
    e3  = bb - 1;
    e31 = bb - 15;
    b_start = 1'b1; b_base = bb; b_mod = bm;
    @(negedge clk);
    b_start = 1'b0;
    n = 1;
    while (!b_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_latency", n, 32);
    chk("t6_ready", b_ready, 1);
    chk("t6_no_err", b_err, 0);
    b_req = 2'b11; b_idx = {5'd3, 5'd2};
    @(negedge clk);
    b_req = '0;
    chk("t6_vld", b_vld, 2'b11);
    chk("t6_e2_hi", b_data[1023:512], e2[1023:512]);
    chk("t6_e2_lo", b_data[511:0], e2[511:0]);
    chk("t6_e3_hi", b_data[2047:1536], e3[1023:512]);
    chk("t6_e3_lo", b_data[1535:1024], e3[511:0]);
    b_req = 2'b11; b_idx = {5'd31, 5'd1};
    @(negedge clk);
    b_req = '0;
    chk("t6_e1_hi", b_data[1023:512], bb[1023:512]);
    chk("t6_e1_lo", b_data[511:0], bb[511:0]);
    chk("t6_e31_hi", b_data[2047:1536], e31[1023:512]);
    chk("t6_e31_lo", b_data[1535:1024], e31[511:0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
